// File: rtl/swallow_ctrl.sv
// Pulse-swallow modulus controller for an 8/9 dual-modulus prescaler.
// Each frame spans P_act prescaler periods, S_act of them at /9, for N = 8*P_act + S_act input cycles.
module swallow_ctrl #(
    parameter int P_WIDTH = 8,
    parameter int S_WIDTH = 3,
    parameter int P_RST   = 10,
    parameter int S_RST   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [P_WIDTH-1:0] p_cfg,
    input  logic [S_WIDTH-1:0] s_cfg,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    output logic               cfg_err,
    output logic               mc,
    output logic               div_out,
    output logic               frame
);

    localparam logic [P_WIDTH-1:0] P_RST_V = P_WIDTH'(P_RST);
    localparam logic [S_WIDTH-1:0] S_RST_V = S_WIDTH'(S_RST);
    localparam logic [P_WIDTH-1:0] ONE_P   = P_WIDTH'(1);
    localparam logic [P_WIDTH-1:0] TWO_P   = P_WIDTH'(2);
    localparam logic [P_WIDTH:0]   ONE_H   = (P_WIDTH+1)'(1);

    logic [P_WIDTH-1:0] k_q, k_d;
    logic [P_WIDTH-1:0] p_act_q, p_act_d;
    logic [S_WIDTH-1:0] s_act_q, s_act_d;
    logic [P_WIDTH-1:0] pend_p_q, pend_p_d;
    logic [S_WIDTH-1:0] pend_s_q, pend_s_d;
    logic               pend_q, pend_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic               mc_q, mc_d;
    logic               div_q, div_d;
    logic               frame_q, frame_d;

    logic               wrap;
    logic               accept;
    logic               req_ok;
    logic [P_WIDTH:0]   half_p;

    assign wrap   = en && (k_q == (p_act_q - ONE_P));
    assign accept = cfg_valid && ready_q;
    assign req_ok = (p_cfg >= TWO_P) && (P_WIDTH'(s_cfg) <= p_cfg);

    always_comb begin
        k_d      = k_q;
        p_act_d  = p_act_q;
        s_act_d  = s_act_q;
        pend_p_d = pend_p_q;
        pend_s_d = pend_s_q;
        pend_d   = pend_q;
        err_d    = 1'b0;
        mc_d     = 1'b0;
        div_d    = div_q;
        frame_d  = 1'b0;
        half_p   = '0;

        if (en) begin
            if (wrap) begin
                k_d     = '0;
                frame_d = 1'b1;
                if (pend_q) begin
                    p_act_d = pend_p_q;
                    s_act_d = pend_s_q;
                    pend_d  = 1'b0;
                end
            end else begin
                k_d = k_q + ONE_P;
            end
            // Outputs describe the period being entered, so use the post-edge k and config.
            half_p = ({1'b0, p_act_d} + ONE_H) >> 1;
            mc_d   = (k_d < P_WIDTH'(s_act_d));
            div_d  = ({1'b0, k_d} < half_p);
        end

        // Acceptance needs an empty pending slot and application needs a full one, so they never collide.
        if (accept) begin
            if (req_ok) begin
                pend_d   = 1'b1;
                pend_p_d = p_cfg;
                pend_s_d = s_cfg;
            end else begin
                err_d = 1'b1;
            end
        end

        ready_d = !pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= '0;
            p_act_q  <= P_RST_V;
            s_act_q  <= S_RST_V;
            pend_p_q <= '0;
            pend_s_q <= '0;
            pend_q   <= 1'b0;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
            mc_q     <= (S_RST != 0);
            div_q    <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            k_q      <= k_d;
            p_act_q  <= p_act_d;
            s_act_q  <= s_act_d;
            pend_p_q <= pend_p_d;
            pend_s_q <= pend_s_d;
            pend_q   <= pend_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            mc_q     <= mc_d;
            div_q    <= div_d;
            frame_q  <= frame_d;
        end
    end

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign mc        = mc_q;
    assign div_out   = div_q;
    assign frame     = frame_q;

endmodule

// File: tb/tb_swallow_ctrl.sv
// Bench for swallow_ctrl: an 8/9 prescaler model makes the DUT clock from a fast input clock;
// a frame-level reference model feeds a scoreboard checked by an independent monitor.
module tb_swallow_ctrl;

    localparam int P_RST = 10;
    localparam int S_RST = 0;

    logic       fin = 1'b0;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] p_cfg = '0;
    logic [2:0] s_cfg = '0;
    logic       cfg_ready, cfg_err, mc, div_out, frame;

    int total = 0;
    int bad   = 0;

    swallow_ctrl #(.P_WIDTH(8), .S_WIDTH(3), .P_RST(P_RST), .S_RST(S_RST)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .p_cfg(p_cfg), .s_cfg(s_cfg),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .mc(mc), .div_out(div_out), .frame(frame)
    );

    always #5 fin = ~fin;

    typedef struct packed {
        logic mc;
        logic dv;
        logic fr;
        logic rdy;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   len_q[$];

    // Reference model state: frame position, active and pending configuration.
    int m_k, m_p, m_s, m_pp, m_ps;
    bit m_pend, m_div, m_began, m_stall;

    int t_fin = 0;
    int period_start = 0;
    int rest = 4;
    bit have_prev = 0;
    int prev_start = 0;

    task automatic chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_k = 0; m_p = P_RST; m_s = S_RST; m_pp = 0; m_ps = 0;
        m_pend = 0; m_div = 1; m_began = 0; m_stall = 0;
    endtask

    task automatic model_edge(bit e, bit v, int p, int s);
        exp_t x;
        bit rdy_before = !m_pend;
        bit err = 0;
        bit fr = 0;
        bit mcv = 0;
        if (e) begin
            if (m_k == m_p - 1) begin
                if (m_began) len_q.push_back(m_stall ? -1 : 8 * m_p + m_s);
                m_began = 1; m_stall = 0; m_k = 0; fr = 1;
                if (m_pend) begin
                    m_p = m_pp; m_s = m_ps; m_pend = 0;
                end
            end else begin
                m_k++;
            end
            mcv   = (m_k < m_s);
            m_div = (m_k < (m_p + 1) / 2);
        end else begin
            m_stall = 1;
        end
        if (v && rdy_before) begin
            if (p >= 2 && s <= p) begin
                m_pend = 1; m_pp = p; m_ps = s;
            end else begin
                err = 1;
            end
        end
        x.mc = mcv; x.dv = m_div; x.fr = fr; x.rdy = !m_pend; x.err = err;
        exp_q.push_back(x);
    endtask

    // One prescaler period: inputs set while clk is low, then a rising edge, then /8 or /9 from mc.
    task automatic step(bit e, bit v, int p, int s);
        en = e; cfg_valid = v; p_cfg = 8'(p); s_cfg = 3'(s);
        repeat (rest) @(posedge fin);
        t_fin += rest;
        clk = 1'b1;
        period_start = t_fin;
        #1 model_edge(e, v, p, s);
        repeat (4) @(posedge fin);
        t_fin += 4;
        rest = mc ? 5 : 4;
        clk = 1'b0;
    endtask

    task automatic run(int n);
        repeat (n) step(1, 0, 0, 0);
    endtask

    task automatic settle();
        int g = 0;
        while (m_pend && g < 2000) begin
            step(1, 0, 0, 0);
            g++;
        end
    endtask

    task automatic load(int p, int s);
        settle();
        step(1, 1, p, s);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_mc"}, mc, (S_RST != 0) ? 1 : 0);
        chk({tag, "_div_out"}, div_out, 1);
        chk({tag, "_frame"}, frame, 0);
        chk({tag, "_cfg_ready"}, cfg_ready, 1);
        chk({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    task automatic reset_mid();
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        exp_q.delete();
        len_q.delete();
        have_prev = 0;
        @(posedge fin);
        t_fin++;
        rst_n = 1'b1;
        rest = mc ? 5 : 4;
    endtask

    // Scoreboard monitor: samples on the falling clk edge, mid-period.
    initial begin
        exp_t x;
        int   l;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard: DUT cycle with no expected entry at %0t", $time);
            end else begin
                x = exp_q.pop_front();
                chk("mc", mc, x.mc);
                chk("div_out", div_out, x.dv);
                chk("frame", frame, x.fr);
                chk("cfg_ready", cfg_ready, x.rdy);
                chk("cfg_err", cfg_err, x.err);
            end
            if (frame) begin
                if (have_prev) begin
                    if (len_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL frame_len: unexpected strobe at %0t", $time);
                    end else begin
                        l = len_q.pop_front();
                        if (l >= 0) chk("frame_len", period_start - prev_start, l);
                    end
                end
                have_prev  = 1;
                prev_start = period_start;
            end
        end
    end

    initial begin
        int g;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge fin);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        run(25);

        g = 0;
        while (m_k != 5 && g < 100) begin step(1, 0, 0, 0); g++; end
        step(1, 1, 10, 3);
        run(30);

        step(1, 1, 1, 0);
        run(2);
        step(1, 1, 5, 7);
        run(25);

        step(1, 1, 12, 5);
        step(1, 1, 4, 1);
        settle();
        run(30);

        load(2, 2);
        settle();
        run(12);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 20), $urandom_range(0, 7));
        end

        load(10, 0);
        settle();
        g = 0;
        while (m_k != 1 && g < 100) begin step(1, 0, 0, 0); g++; end
        step(1, 1, 6, 1);
        run(2);
        reset_mid();
        run(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/swallow_ctrl.md
Name: swallow_ctrl

Overview:
- Pulse-swallow modulus controller for the 8/9 dual-modulus prescaler.
- Clocked by the prescaler output, its `f89` signal. Drives the prescaler `MC` input so each output frame lasts N = 8*P + S input-clock cycles.
- Produces the divided output and a frame strobe for the downstream phase detector and sigma-delta modulator.
- Accepts (P,S) updates through a valid/ready handshake and applies them only on frame boundaries, so the per-frame modulus never glitches.

Parameters:
- P_WIDTH, 8, width of the P (program) count; P range 2..2^P_WIDTH-1.
- S_WIDTH, 3, width of the S (swallow) count; S range 0..7, fixed by the 8/9 prescaler.
- P_RST, 10, P value active out of reset.
- S_RST, 0, S value active out of reset; must satisfy S_RST <= P_RST.

Ports:
- clk  in  1  prescaler output clock (`f89`); one edge per prescaler period.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable.
- p_cfg  in  P_WIDTH  requested P.
- s_cfg  in  S_WIDTH  requested S.
- cfg_valid  in  1  request strobe for p_cfg/s_cfg.
- cfg_ready  out  1  controller can accept a new request.
- cfg_err  out  1  one-cycle pulse: request rejected.
- mc  out  1  modulus control to the prescaler (1 = divide by 9).
- div_out  out  1  divided output, approximately 50% duty.
- frame  out  1  one-cycle strobe in period k=0 of each frame.

Behaviour:
- Reset is asynchronous and active-low. All state and outputs are registered. Reset values:
  - k=0, P_act=P_RST, S_act=S_RST, pending empty.
  - cfg_ready=1, cfg_err=0.
  - mc=(S_RST!=0), div_out=1, frame=0.
- Frame counter k:
  - k counts prescaler periods 0..P_act-1.
  - k advances on each clk edge when en=1.
  - From k=P_act-1 it wraps to 0.
- Registered outputs for period k, with values valid during that period:
  - mc=1 iff k<S_act. Over one frame the prescaler divides by 9 S_act times and by 8 (P_act-S_act) times, giving N=8*P_act+S_act.
  - div_out=1 iff k < (P_act+1)>>1.
  - frame=1 iff k==0 was entered by a wrap. It is not asserted on the first frame after reset.
- Config handshake:
  - A request is accepted when cfg_valid & cfg_ready.
  - Validity rule: 2 <= p_cfg and s_cfg <= p_cfg.
  - A valid request is latched into the pending register, and cfg_ready drops on the next edge.
  - An invalid request is not captured: cfg_err pulses for 1 cycle, and cfg_ready stays 1.
  - cfg_valid while cfg_ready=0 is ignored; no error is raised.
- Config application:
  - On the wrap edge (k==P_act-1, en=1), pending (if any) is copied to P_act/S_act and pending clears.
  - cfg_ready returns to 1 on that same edge.
  - The outputs for new k=0 are computed from the new P_act/S_act.
  - Acceptance on the wrap edge itself applies at the following wrap, not the current one.
- en=0:
  - k, P_act, S_act and div_out hold.
  - mc is forced to 0, so the prescaler runs at /8.
  - frame is 0.
  - The handshake still operates, but pending is not applied until counting resumes and wraps.
- S_act=0: mc stays 0 for the whole frame, and N=8*P_act.
- S_act=P_act: mc stays 1 for the whole frame, and N=9*P_act.
- Reset mid-frame returns to the reset state immediately. Any pending config is discarded.
- Latency: outputs change on the same clk edge that advances k. No combinational path exists from inputs to mc/div_out/frame.

Test Plan:
- Reset, P_RST=10, S_RST=0, en=1, with a behavioural 8/9 prescaler model:
  - frame period = 80 input cycles;
  - mc never high;
  - div_out high 5 of 10 prescaler periods.
- Load P=10, S=3 mid-frame:
  - cfg_ready low until the wrap;
  - the current frame stays 80 cycles;
  - the next frame is 83 cycles, with mc high for k=0..2.
- Load P=2, S=2:
  - frames are 18 cycles;
  - mc is constantly 1;
  - frame strobe every 2 clk edges;
  - div_out alternates 1,0.
- Invalid requests (P=1,S=0) and (P=5,S=7):
  - cfg_err pulses 1 cycle each;
  - cfg_ready stays 1;
  - the N=83 frame length is unchanged.
- Back-to-back valid requests:
  - the second is ignored while cfg_ready=0;
  - only the first takes effect at the wrap.
- Assert rst_n low at k=4 with a pending request:
  - outputs are at reset values immediately;
  - pending is lost;
  - the frame length returns to 80.
